// File: rtl/barrel_shifter_pkg.sv
// Shared definitions for the pipelined barrel shifter: mode encoding and a width sanity helper.
package barrel_shifter_pkg;

    typedef enum logic [1:0] {
        SHIFT_LOGICAL_RIGHT    = 2'd0,
        SHIFT_ARITHMETIC_RIGHT = 2'd1,
        SHIFT_LOGICAL_LEFT     = 2'd2,
        SHIFT_ROTATE_RIGHT     = 2'd3
    } shift_mode_t;

    function automatic bit is_pow2(input int unsigned value);
        return (value >= 2) && ((value & (value - 1)) == 0);
    endfunction

endpackage

// File: rtl/barrel_shifter_stage.sv
// One barrel-shifter level: conditional shift by 2**STAGE_INDEX plus its register slice and ready.
// The rotate path exists only when BARREL_SHIFTER_ROTATE_EN is defined.
module barrel_shifter_stage
    import barrel_shifter_pkg::*;
#(
    parameter int   WIDTH        = 8,
    parameter int   AMOUNT_WIDTH = 3,
    parameter logic PAD_VALUE    = 1'b0,
    parameter int   STAGE_INDEX  = 0
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [WIDTH-1:0]        i_data,
    input  logic [AMOUNT_WIDTH-1:0] i_amount,
    input  logic [1:0]              i_mode,
    input  logic                    i_valid,
    output logic                    o_ready,
    output logic [WIDTH-1:0]        o_data,
    output logic [AMOUNT_WIDTH-1:0] o_amount,
    output logic [1:0]              o_mode,
    output logic                    o_valid,
    input  logic                    i_ready
);

    localparam int SHIFT = 1 << STAGE_INDEX;

    logic [WIDTH-1:0]        w_lr;
    logic [WIDTH-1:0]        w_ar;
    logic [WIDTH-1:0]        w_ll;
    logic [WIDTH-1:0]        w_shifted;
    logic [WIDTH-1:0]        w_result;
`ifdef BARREL_SHIFTER_ROTATE_EN
    logic [WIDTH-1:0]        w_rr;
`endif

    logic                    r_valid;
    logic [WIDTH-1:0]        r_data;
    logic [AMOUNT_WIDTH-1:0] r_amount;
    logic [1:0]              r_mode;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bit
            if (gi + SHIFT < WIDTH) begin : g_right_src
                assign w_lr[gi] = i_data[gi + SHIFT];
                assign w_ar[gi] = i_data[gi + SHIFT];
            end else begin : g_right_fill
                // The sign bit never changes between stages, so the local MSB is the original MSB.
                assign w_lr[gi] = PAD_VALUE;
                assign w_ar[gi] = i_data[WIDTH-1];
            end
            if (gi >= SHIFT) begin : g_left_src
                assign w_ll[gi] = i_data[gi - SHIFT];
            end else begin : g_left_fill
                assign w_ll[gi] = PAD_VALUE;
            end
`ifdef BARREL_SHIFTER_ROTATE_EN
            assign w_rr[gi] = i_data[(gi + SHIFT) % WIDTH];
`endif
        end
    endgenerate

    always_comb begin
        w_shifted = w_lr;
        case (i_mode)
            SHIFT_ARITHMETIC_RIGHT: w_shifted = w_ar;
            SHIFT_LOGICAL_LEFT:     w_shifted = w_ll;
`ifdef BARREL_SHIFTER_ROTATE_EN
            SHIFT_ROTATE_RIGHT:     w_shifted = w_rr;
`endif
            default:                w_shifted = w_lr;
        endcase
    end

    assign w_result = i_amount[STAGE_INDEX] ? w_shifted : i_data;

    // A slot can load when empty or when its occupant leaves this same cycle.
    assign o_ready = !r_valid || i_ready;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_valid  <= 1'b0;
            r_data   <= '0;
            r_amount <= '0;
            r_mode   <= '0;
        end else if (o_ready) begin
            r_valid <= i_valid;
            if (i_valid) begin
                r_data   <= w_result;
                r_amount <= i_amount;
                r_mode   <= i_mode;
            end
        end
    end

    assign o_valid  = r_valid;
    assign o_data   = r_data;
    assign o_amount = r_amount;
    assign o_mode   = r_mode;

endmodule

// File: rtl/barrel_shifter.sv
// Pipelined barrel shifter, one stage per amount bit, valid/ready with full backpressure.
// Define BARREL_SHIFTER_ROTATE_EN to build rotate right for mode 3 (otherwise logical right).
module barrel_shifter
    import barrel_shifter_pkg::*;
#(
    parameter int    WIDTH        = 8,
    parameter logic  PAD_VALUE    = 1'b0,
    localparam int   AMOUNT_WIDTH = $clog2(WIDTH)
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [WIDTH-1:0]        in_data,
    input  logic [AMOUNT_WIDTH-1:0] in_amount,
    input  logic [1:0]              in_mode,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic                    out_valid,
    input  logic                    out_ready
);

    if (!is_pow2(WIDTH)) begin : g_bad_width
        $error("barrel_shifter: WIDTH must be a power of two and at least 2");
    end

    genvar gi;
    generate
        for (gi = 0; gi < AMOUNT_WIDTH; gi++) begin : g_stage
            logic [WIDTH-1:0]        w_data;
            logic [AMOUNT_WIDTH-1:0] w_amount;
            logic [1:0]              w_mode;
            logic                    w_valid;
            logic                    w_ready;
            logic [WIDTH-1:0]        w_up_data;
            logic [AMOUNT_WIDTH-1:0] w_up_amount;
            logic [1:0]              w_up_mode;
            logic                    w_up_valid;
            logic                    w_down_ready;

            if (gi == 0) begin : g_head
                assign w_up_data   = in_data;
                assign w_up_amount = in_amount;
                assign w_up_mode   = in_mode;
                assign w_up_valid  = in_valid;
            end else begin : g_link
                assign w_up_data   = g_stage[gi-1].w_data;
                assign w_up_amount = g_stage[gi-1].w_amount;
                assign w_up_mode   = g_stage[gi-1].w_mode;
                assign w_up_valid  = g_stage[gi-1].w_valid;
            end

            // Ready ripples combinationally from the consumer back to the input.
            if (gi == AMOUNT_WIDTH - 1) begin : g_tail
                assign w_down_ready = out_ready;
            end else begin : g_mid
                assign w_down_ready = g_stage[gi+1].w_ready;
            end

            barrel_shifter_stage #(
                .WIDTH        (WIDTH),
                .AMOUNT_WIDTH (AMOUNT_WIDTH),
                .PAD_VALUE    (PAD_VALUE),
                .STAGE_INDEX  (gi)
            ) u_stage (
                .clock    (clock),
                .reset    (reset),
                .i_data   (w_up_data),
                .i_amount (w_up_amount),
                .i_mode   (w_up_mode),
                .i_valid  (w_up_valid),
                .o_ready  (w_ready),
                .o_data   (w_data),
                .o_amount (w_amount),
                .o_mode   (w_mode),
                .o_valid  (w_valid),
                .i_ready  (w_down_ready)
            );
        end
    endgenerate

    assign in_ready  = g_stage[0].w_ready;
    assign out_data  = g_stage[AMOUNT_WIDTH-1].w_data;
    assign out_valid = g_stage[AMOUNT_WIDTH-1].w_valid;

    logic [AMOUNT_WIDTH+1:0] w_unused_tail;
    assign w_unused_tail = {g_stage[AMOUNT_WIDTH-1].w_amount, g_stage[AMOUNT_WIDTH-1].w_mode};

endmodule

// File: tb/tb_barrel_shifter.sv
// Self-checking bench for barrel_shifter (WIDTH=8, PAD_VALUE=0): vector table, streaming,
// backpressure, random handshake and reset-in-flight sequences against a queue scoreboard.
module tb_barrel_shifter;

    logic       clock = 1'b0;
    logic       reset;
    logic [7:0] in_data;
    logic [2:0] in_amount;
    logic [1:0] in_mode;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;

    barrel_shifter #(.WIDTH(8), .PAD_VALUE(1'b0)) dut (
        .clock     (clock),
        .reset     (reset),
        .in_data   (in_data),
        .in_amount (in_amount),
        .in_mode   (in_mode),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [7:0] data;
        logic [2:0] amt;
        logic [1:0] mode;
        logic [7:0] expect_val;
    } vec_t;

    int n_pass = 0;
    int n_total = 0;
    int n_acc = 0;
    int n_out = 0;
    int n_stall = 0;
    int cyc = 0;
    int ov_count = 0;
    int ov_first = 0;
    int ov_last = 0;
    logic [7:0] cur_exp = 8'h00;
    logic [7:0] sb[$];
    bit rnd_ready = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    endtask

    function automatic logic [7:0] model(input logic [7:0] d, input logic [2:0] a, input logic [1:0] m);
        logic signed [7:0] s;
        logic [15:0] dd;
        s = d;
        dd = {d, d} >> a;
        case (m)
            2'd0: return d >> a;
            2'd1: return s >>> a;
            2'd2: return d << a;
`ifdef BARREL_SHIFTER_ROTATE_EN
            default: return dd[7:0];
`else
            default: return d >> a;
`endif
        endcase
    endfunction

    // Handshakes are sampled mid-cycle; inputs only change just after the rising edge.
    always @(negedge clock) begin
        if (!reset) begin
            if (out_valid) begin
                if (ov_count == 0) ov_first = cyc;
                ov_last = cyc;
                ov_count++;
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    n_total++;
                    $display("FAIL sb_underflow: got result 0x%0h, required no result", out_data);
                end else begin
                    check("result", 32'(out_data), 32'(sb.pop_front()));
                end
                n_out++;
            end
            if (in_valid && in_ready) begin
                sb.push_back(cur_exp);
                n_acc++;
            end
        end
        cyc++;
    end

    task automatic step_cycle(output bit acc);
        @(negedge clock);
        acc = in_valid && in_ready;
        @(posedge clock);
        #1;
        if (rnd_ready) out_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic send_op(input logic [7:0] d, input logic [2:0] a, input logic [1:0] m,
                           input logic [7:0] e, input int idle);
        bit acc = 1'b0;
        bit dummy;
        int tries = 0;
        in_valid = 1'b0;
        repeat (idle) step_cycle(dummy);
        in_data = d;
        in_amount = a;
        in_mode = m;
        cur_exp = e;
        in_valid = 1'b1;
        while (!acc && tries < 500) begin
            step_cycle(acc);
            tries++;
        end
        if (!acc) begin
            n_total++;
            $display("FAIL send_timeout: got no accept in %0d cycles, required accept", tries);
        end
        n_stall += tries - 1;
        in_valid = 1'b0;
    endtask

    task automatic wait_drain(input int max_cycles);
        bit dummy;
        for (int i = 0; i < max_cycles; i++) begin
            if (sb.size() == 0 && !out_valid) break;
            step_cycle(dummy);
        end
        check("drain_empty", 32'(sb.size()), 32'd0);
    endtask

    task automatic wait_first_out(input int c0, input string name);
        bit dummy;
        for (int i = 0; i < 20; i++) begin
            if (ov_count > 0) break;
            step_cycle(dummy);
        end
        check(name, 32'(ov_first - c0), 32'd3);
    endtask

    initial begin
        vec_t vecs[12];
        bit dummy;
        bit acc;
        int c0;
        int n_out0;
        int n_acc0;
        int acc_cnt;
        bit held_v;
        logic [7:0] held;
        logic [7:0] d;
        logic [2:0] a;
        logic [1:0] m;

        vecs[0]  = '{8'hB4, 3'd3, 2'd0, 8'h16};
        vecs[1]  = '{8'hB4, 3'd3, 2'd1, 8'hF6};
        vecs[2]  = '{8'hB4, 3'd3, 2'd2, 8'hA0};
`ifdef BARREL_SHIFTER_ROTATE_EN
        vecs[3]  = '{8'hB4, 3'd3, 2'd3, 8'h96};
        vecs[11] = '{8'h81, 3'd7, 2'd3, 8'h03};
`else
        vecs[3]  = '{8'hB4, 3'd3, 2'd3, 8'h16};
        vecs[11] = '{8'h81, 3'd7, 2'd3, 8'h01};
`endif
        vecs[4]  = '{8'h81, 3'd0, 2'd0, 8'h81};
        vecs[5]  = '{8'h81, 3'd0, 2'd1, 8'h81};
        vecs[6]  = '{8'h81, 3'd0, 2'd2, 8'h81};
        vecs[7]  = '{8'h81, 3'd0, 2'd3, 8'h81};
        vecs[8]  = '{8'h81, 3'd7, 2'd0, 8'h01};
        vecs[9]  = '{8'h81, 3'd7, 2'd1, 8'hFF};
        vecs[10] = '{8'h81, 3'd7, 2'd2, 8'h80};

        reset = 1'b1;
        in_valid = 1'b0;
        in_data = 8'h00;
        in_amount = 3'd0;
        in_mode = 2'd0;
        out_ready = 1'b1;

        #2;
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_out_data", 32'(out_data), 32'd0);
        check("reset_in_ready", 32'(in_ready), 32'd1);
        @(posedge clock);
        @(posedge clock);
        #2 reset = 1'b0;
        check("in_ready_after_reset", 32'(in_ready), 32'd1);
        @(posedge clock);
        #1;

        // Vector table; the first entry also measures latency from an empty pipe.
        ov_count = 0;
        c0 = cyc;
        send_op(vecs[0].data, vecs[0].amt, vecs[0].mode, vecs[0].expect_val, 0);
        wait_first_out(c0, "latency_first");
        for (int i = 1; i < 12; i++)
            send_op(vecs[i].data, vecs[i].amt, vecs[i].mode, vecs[i].expect_val, 0);
        wait_drain(20);

        // Streaming: 16 back-to-back operands with out_ready held high.
        ov_count = 0;
        n_stall = 0;
        n_out0 = n_out;
        c0 = cyc;
        for (int i = 0; i < 16; i++) begin
            d = 8'($urandom);
            a = 3'($urandom);
            m = 2'($urandom);
            send_op(d, a, m, model(d, a, m), 0);
        end
        wait_drain(20);
        check("stream_in_ready_stalls", 32'(n_stall), 32'd0);
        check("stream_out_valid_cycles", 32'(ov_count), 32'd16);
        check("stream_out_valid_span", 32'(ov_last - ov_first), 32'd15);
        check("stream_latency", 32'(ov_first - c0), 32'd3);
        check("stream_results", 32'(n_out - n_out0), 32'd16);

        // Backpressure: 10 cycles of offered input with the consumer stalled.
        out_ready = 1'b0;
        acc_cnt = 0;
        held_v = 1'b0;
        held = 8'h00;
        n_out0 = n_out;
        d = 8'($urandom); a = 3'($urandom); m = 2'($urandom);
        in_data = d; in_amount = a; in_mode = m; cur_exp = model(d, a, m);
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step_cycle(acc);
            if (acc) begin
                acc_cnt++;
                d = 8'($urandom); a = 3'($urandom); m = 2'($urandom);
                in_data = d; in_amount = a; in_mode = m; cur_exp = model(d, a, m);
            end
            if (out_valid) begin
                if (held_v) check("hold_stable", 32'(out_data), 32'(held));
                else begin
                    held = out_data;
                    held_v = 1'b1;
                end
            end
        end
        check("bp_accepted", 32'(acc_cnt), 32'd3);
        check("bp_in_ready_low", 32'(in_ready), 32'd0);
        check("bp_out_valid", 32'(out_valid), 32'd1);
        in_valid = 1'b0;
        out_ready = 1'b1;
        #1;
        check("bp_in_ready_follows", 32'(in_ready), 32'd1);
        wait_drain(20);
        check("bp_drained", 32'(n_out - n_out0), 32'd3);

        // Random in_valid gaps and random out_ready over 10k operands.
        rnd_ready = 1'b1;
        n_out0 = n_out;
        n_acc0 = n_acc;
        for (int i = 0; i < 10000; i++) begin
            d = 8'($urandom); a = 3'($urandom); m = 2'($urandom);
            send_op(d, a, m, model(d, a, m), ($urandom_range(0, 9) < 3) ? 1 : 0);
        end
        rnd_ready = 1'b0;
        out_ready = 1'b1;
        wait_drain(50);
        check("rand_accepted", 32'(n_acc - n_acc0), 32'd10000);
        check("rand_emitted", 32'(n_out - n_out0), 32'd10000);

        // Reset with two operands in flight, one already presented at the output.
        out_ready = 1'b0;
        send_op(8'hB4, 3'd0, 2'd2, 8'hB4, 0);
        send_op(8'h5A, 3'd1, 2'd0, 8'h2D, 0);
        repeat (2) step_cycle(dummy);
        check("pre_reset_out_valid", 32'(out_valid), 32'd1);
        check("pre_reset_out_data", 32'(out_data), 32'hB4);
        #1 reset = 1'b1;
        sb.delete();
        #1;
        check("mid_reset_out_valid", 32'(out_valid), 32'd0);
        check("mid_reset_out_data", 32'(out_data), 32'd0);
        check("mid_reset_in_ready", 32'(in_ready), 32'd1);
        @(posedge clock);
        @(posedge clock);
        #2 reset = 1'b0;
        out_ready = 1'b1;
        ov_count = 0;
        repeat (6) step_cycle(dummy);
        check("no_stale_result", 32'(ov_count), 32'd0);
        c0 = cyc;
        send_op(8'hC3, 3'd2, 2'd1, 8'hF0, 0);
        wait_first_out(c0, "latency_after_reset");
        wait_drain(20);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
